// File: rtl/maze_game_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : maze_game_controller_if
// Brief    : Button, maze and status bundle between the maze game controller
//            and its surroundings (debouncers, renderer, score display).
// Revision : 1.0 - initial release
// ============================================================================
interface maze_game_controller_if #(
    parameter int CELLS = 198
);
    // Inputs to the controller
    logic              tick;
    logic              UPbtn;
    logic              DOWNbtn;
    logic              RIGHTbtn;
    logic              LEFTbtn;
    logic              CTRLbtn;
    logic              game_pause;
    logic [CELLS-1:0]  mazestate;
    logic [7:0]        begin_spot;
    logic [7:0]        goal_spot;

    // Outputs from the controller
    logic [7:0]        position;
    logic [2:0]        state;
    logic [1:0]        lives;
    logic [9:0]        moves;
    logic [15:0]       elapsed;
    logic              step_pulse;
    logic              crash_pulse;

    // Environment side: drives buttons and maze, reads game status
    modport master (
        output tick, UPbtn, DOWNbtn, RIGHTbtn, LEFTbtn, CTRLbtn, game_pause,
               mazestate, begin_spot, goal_spot,
        input  position, state, lives, moves, elapsed, step_pulse, crash_pulse
    );

    // Controller side
    modport slave (
        input  tick, UPbtn, DOWNbtn, RIGHTbtn, LEFTbtn, CTRLbtn, game_pause,
               mazestate, begin_spot, goal_spot,
        output position, state, lives, moves, elapsed, step_pulse, crash_pulse
    );
endinterface
`default_nettype wire

// File: rtl/maze_game_controller.sv
`default_nettype none
// ============================================================================
// Module   : maze_game_controller
// Brief    : Maze game sequencer. Holds player position, lives, move and tick
//            counters; resolves button moves against the maze bitmap on each
//            qualifying tick (tick=1 and game_pause=1).
// Revision : 1.0 - initial release
// ============================================================================
module maze_game_controller #(
    parameter int WIDTH     = 18,
    parameter int HEIGHT    = 11,
    parameter int START_POS = 181,
    parameter int LIVES     = 3,
    parameter int CRASH_POS = 255
) (
    input  wire logic              CLK,
    input  wire logic              RESET,
    maze_game_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_CRASH = 3'd2,
        S_WIN   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // Geometry constants in the 9-bit arithmetic domain used for targets
    localparam logic [8:0] C_W        = 9'(WIDTH);
    localparam logic [8:0] C_CELLS    = 9'(WIDTH * HEIGHT);
    localparam logic [8:0] C_LAST_ROW = 9'((HEIGHT - 1) * WIDTH);
    localparam logic [4:0] C_LAST_COL = 5'(WIDTH - 1);
    localparam logic [7:0] C_START    = 8'(START_POS);
    localparam logic [7:0] C_CRASH    = 8'(CRASH_POS);
    localparam logic [1:0] C_LIVES    = 2'(LIVES);

    state_t       state_q,   state_d;
    logic [7:0]   pos_q,     pos_d;
    logic [4:0]   col_q,     col_d;
    logic [1:0]   lives_q,   lives_d;
    logic [9:0]   moves_q,   moves_d;
    logic [15:0]  elapsed_q, elapsed_d;
    logic         step_q,    step_d;
    logic         crash_q,   crash_d;

    logic         w_qual;
    logic [8:0]   w_pos9;
    logic [8:0]   w_begin9;
    logic [8:0]   w_begin_base;
    logic [4:0]   w_begin_col;
    logic         w_begin_ok;
    logic         w_dir;
    logic         w_oob;
    logic [8:0]   w_target9;
    logic [4:0]   w_tcol;
    logic         w_target_open;

    assign w_qual   = bus.tick & bus.game_pause;
    assign w_pos9   = {1'b0, pos_q};
    assign w_begin9 = {1'b0, bus.begin_spot};

    // Start cell row base by comparison against each row boundary (no divider)
    always_comb begin
        w_begin_base = '0;
        for (int r = 1; r < HEIGHT; r++) begin
            if (w_begin9 >= 9'(r * WIDTH)) begin
                w_begin_base = 9'(r * WIDTH);
            end
        end
    end

    assign w_begin_col = 5'(w_begin9 - w_begin_base);
    assign w_begin_ok  = (w_begin9 < C_CELLS) ? bus.mazestate[bus.begin_spot] : 1'b0;

    // Resolve the prioritised direction into a 9-bit target and grid-edge flag
    always_comb begin
        w_dir     = 1'b1;
        w_oob     = 1'b0;
        w_target9 = w_pos9;
        w_tcol    = col_q;
        if (bus.UPbtn) begin
            w_oob     = (w_pos9 < C_W);
            w_target9 = w_pos9 - C_W;
        end else if (bus.DOWNbtn) begin
            w_oob     = (w_pos9 >= C_LAST_ROW);
            w_target9 = w_pos9 + C_W;
        end else if (bus.RIGHTbtn) begin
            w_oob     = (col_q == C_LAST_COL);
            w_target9 = w_pos9 + 9'd1;
            w_tcol    = col_q + 5'd1;
        end else if (bus.LEFTbtn) begin
            w_oob     = (col_q == 5'd0);
            w_target9 = w_pos9 - 9'd1;
            w_tcol    = col_q - 5'd1;
        end else begin
            w_dir     = 1'b0;
        end
    end

    // The range guard keeps the bitmap lookup inside the maze for any target
    assign w_target_open = (!w_oob && (w_target9 < C_CELLS))
                         ? bus.mazestate[w_target9[7:0]] : 1'b0;

    // Game sequencing: everything holds unless this is a qualifying tick
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        col_d     = col_q;
        lives_d   = lives_q;
        moves_d   = moves_q;
        elapsed_d = elapsed_q;
        step_d    = 1'b0;
        crash_d   = 1'b0;
        if (w_qual) begin
            case (state_q)
                S_IDLE: begin
                    pos_d = C_START;
                    if (bus.CTRLbtn && w_begin_ok) begin
                        state_d   = S_PLAY;
                        pos_d     = bus.begin_spot;
                        col_d     = w_begin_col;
                        lives_d   = C_LIVES;
                        moves_d   = '0;
                        elapsed_d = '0;
                    end
                end
                S_PLAY: begin
                    if (elapsed_q != 16'hFFFF) begin
                        elapsed_d = elapsed_q + 16'd1;
                    end
                    if (w_dir) begin
                        if (!w_target_open) begin
                            pos_d   = C_CRASH;
                            crash_d = 1'b1;
                            lives_d = lives_q - 2'd1;
                            state_d = (lives_q == 2'd1) ? S_OVER : S_CRASH;
                        end else begin
                            pos_d  = w_target9[7:0];
                            col_d  = w_tcol;
                            step_d = 1'b1;
                            if (moves_q != 10'h3FF) begin
                                moves_d = moves_q + 10'd1;
                            end
                            if (w_target9[7:0] == bus.goal_spot) begin
                                state_d = S_WIN;
                            end
                        end
                    end
                end
                S_CRASH: begin
                    if (bus.CTRLbtn) begin
                        state_d = S_PLAY;
                        pos_d   = bus.begin_spot;
                        col_d   = w_begin_col;
                    end
                end
                S_WIN, S_OVER: begin
                    if (bus.CTRLbtn) begin
                        state_d = S_IDLE;
                        pos_d   = C_START;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    pos_d   = C_START;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            pos_q     <= C_START;
            col_q     <= '0;
            lives_q   <= C_LIVES;
            moves_q   <= '0;
            elapsed_q <= '0;
            step_q    <= 1'b0;
            crash_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            col_q     <= col_d;
            lives_q   <= lives_d;
            moves_q   <= moves_d;
            elapsed_q <= elapsed_d;
            step_q    <= step_d;
            crash_q   <= crash_d;
        end
    end

    assign bus.position    = pos_q;
    assign bus.state       = state_q;
    assign bus.lives       = lives_q;
    assign bus.moves       = moves_q;
    assign bus.elapsed     = elapsed_q;
    assign bus.step_pulse  = step_q;
    assign bus.crash_pulse = crash_q;

endmodule
`default_nettype wire

// File: tb/tb_maze_game_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_maze_game_controller
// Brief    : Directed self-checking bench for maze_game_controller with a
//            row/column behavioural model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maze_game_controller;

    localparam int W = 18;
    localparam int H = 11;
    localparam int N = W * H;
    localparam logic [4:0] B_UP    = 5'b10000;
    localparam logic [4:0] B_DOWN  = 5'b01000;
    localparam logic [4:0] B_RIGHT = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_CTRL  = 5'b00001;
    localparam logic [4:0] B_NONE  = 5'b00000;

    logic CLK;
    logic RESET;
    int   n_checks = 0;
    int   n_pass   = 0;

    maze_game_controller_if #(.CELLS(N)) bus ();

    maze_game_controller #(
        .WIDTH(18), .HEIGHT(11), .START_POS(181), .LIVES(3), .CRASH_POS(255)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: position as (row, col), plain integer rules
    // ------------------------------------------------------------------
    int m_state = 0, m_pos = 181, m_lives = 3, m_moves = 0, m_elapsed = 0;
    int m_step = 0, m_crash = 0;
    bit model_on = 1'b0;

    always @(posedge CLK) begin
        int dr, dc, r, c, t;
        bit dir;
        if (!RESET) begin
            m_state = 0; m_pos = 181; m_lives = 3; m_moves = 0; m_elapsed = 0;
            m_step = 0; m_crash = 0;
        end else begin
            m_step = 0; m_crash = 0;
            if (bus.tick && bus.game_pause) begin
                case (m_state)
                    0: begin
                        m_pos = 181;
                        if (bus.CTRLbtn && bus.begin_spot < N && bus.mazestate[bus.begin_spot]) begin
                            m_state = 1; m_pos = bus.begin_spot; m_lives = 3;
                            m_moves = 0; m_elapsed = 0;
                        end
                    end
                    1: begin
                        if (m_elapsed < 65535) m_elapsed++;
                        dir = 1'b1; dr = 0; dc = 0;
                        if (bus.UPbtn) dr = -1;
                        else if (bus.DOWNbtn) dr = 1;
                        else if (bus.RIGHTbtn) dc = 1;
                        else if (bus.LEFTbtn) dc = -1;
                        else dir = 1'b0;
                        if (dir) begin
                            r = m_pos / W + dr;
                            c = m_pos % W + dc;
                            t = r * W + c;
                            if (r < 0 || r >= H || c < 0 || c >= W || !bus.mazestate[t]) begin
                                m_crash = 1; m_pos = 255; m_lives--;
                                m_state = (m_lives == 0) ? 4 : 2;
                            end else begin
                                m_step = 1; m_pos = t;
                                if (m_moves < 1023) m_moves++;
                                if (t == int'(bus.goal_spot)) m_state = 3;
                            end
                        end
                    end
                    2: if (bus.CTRLbtn) begin m_state = 1; m_pos = bus.begin_spot; end
                    default: if (bus.CTRLbtn) begin m_state = 0; m_pos = 181; end
                endcase
            end
        end
        #1;
        if (model_on) begin
            logic [39:0] act, exp;
            act = {bus.position, 5'(bus.state), bus.lives, bus.moves, bus.elapsed,
                   bus.step_pulse, bus.crash_pulse};
            exp = {8'(m_pos), 5'(m_state), 2'(m_lives), 10'(m_moves), 16'(m_elapsed),
                   1'(m_step), 1'(m_crash)};
            n_checks++;
            if (act == exp) n_pass++;
            else $display("FAIL model_cycle: got %h expected %h (pos,state,lives,moves,elapsed,step,crash)",
                          act, exp);
        end
    end

    // One tick with the given buttons held, then release
    task automatic tick_with(input logic [4:0] b);
        @(negedge CLK);
        {bus.UPbtn, bus.DOWNbtn, bus.RIGHTbtn, bus.LEFTbtn, bus.CTRLbtn} = b;
        bus.tick = 1'b1;
        @(negedge CLK);
        {bus.UPbtn, bus.DOWNbtn, bus.RIGHTbtn, bus.LEFTbtn, bus.CTRLbtn} = B_NONE;
        bus.tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b0;
        bus.tick = 1'b0;
        {bus.UPbtn, bus.DOWNbtn, bus.RIGHTbtn, bus.LEFTbtn, bus.CTRLbtn} = B_NONE;
        bus.game_pause = 1'b1;
        bus.mazestate  = '1;
        bus.begin_spot = 8'd19;
        bus.goal_spot  = 8'd100;
        @(negedge CLK);
        @(negedge CLK);
        model_on = 1'b1;
        chk("reset_state", bus.state, 0);
        chk("reset_pos", bus.position, 181);
        chk("reset_lives", bus.lives, 3);
        chk("reset_moves", bus.moves, 0);
        RESET = 1'b1;

        // Start
        tick_with(B_CTRL);
        chk("start_state", bus.state, 1);
        chk("start_pos", bus.position, 19);
        chk("start_lives", bus.lives, 3);
        chk("start_moves", bus.moves, 0);

        // Move and step pulse
        tick_with(B_RIGHT);
        chk("right_pos", bus.position, 20);
        chk("right_moves", bus.moves, 1);
        chk("step_high", bus.step_pulse, 1);
        @(negedge CLK);
        chk("step_low", bus.step_pulse, 0);
        tick_with(B_UP | B_RIGHT);
        chk("up_prio_pos", bus.position, 2);
        tick_with(B_DOWN);
        chk("down_pos", bus.position, 20);

        // Wall hit then restart
        bus.mazestate[21] = 1'b0;
        tick_with(B_RIGHT);
        chk("wall_pos", bus.position, 255);
        chk("wall_state", bus.state, 2);
        chk("wall_lives", bus.lives, 2);
        chk("wall_crash", bus.crash_pulse, 1);
        tick_with(B_CTRL);
        chk("restart_pos", bus.position, 19);
        chk("restart_state", bus.state, 1);
        bus.mazestate[21] = 1'b1;

        // Right edge: 19 -> 35 then no wrap into 36
        for (int i = 0; i < 16; i++) tick_with(B_RIGHT);
        chk("edge_pos35", bus.position, 35);
        tick_with(B_RIGHT);
        chk("edge_crash_pos", bus.position, 255);
        chk("edge_lives", bus.lives, 1);
        tick_with(B_CTRL);
        tick_with(B_UP);
        chk("row0_pos", bus.position, 1);
        tick_with(B_UP);
        chk("over_state", bus.state, 4);
        chk("over_lives", bus.lives, 0);
        tick_with(B_NONE);
        chk("over_hold", bus.state, 4);
        tick_with(B_CTRL);
        chk("idle_state", bus.state, 0);
        chk("idle_pos", bus.position, 181);

        // Freeze then goal
        tick_with(B_CTRL);
        chk("start2_state", bus.state, 1);
        bus.game_pause = 1'b0;
        for (int i = 0; i < 5; i++) tick_with(B_DOWN);
        chk("frozen_pos", bus.position, 19);
        chk("frozen_elapsed", bus.elapsed, 0);
        bus.goal_spot  = 8'd37;
        bus.game_pause = 1'b1;
        tick_with(B_DOWN);
        chk("goal_pos", bus.position, 37);
        chk("goal_state", bus.state, 3);
        chk("goal_elapsed", bus.elapsed, 1);
        for (int i = 0; i < 3; i++) tick_with(B_RIGHT);
        chk("win_moves_frozen", bus.moves, 1);
        chk("win_pos_frozen", bus.position, 37);
        tick_with(B_CTRL);
        chk("win_to_idle", bus.state, 0);

        // Refused starts
        bus.begin_spot = 8'd200;
        tick_with(B_CTRL);
        chk("refuse_range", bus.state, 0);
        bus.begin_spot = 8'd19;
        bus.mazestate[19] = 1'b0;
        tick_with(B_CTRL);
        chk("refuse_wall", bus.state, 0);
        bus.mazestate[19] = 1'b1;

        // Left edge crash, then saturation run in row 1
        bus.goal_spot = 8'd0;
        tick_with(B_CTRL);
        tick_with(B_LEFT);
        chk("left_pos18", bus.position, 18);
        tick_with(B_LEFT);
        chk("left_edge_state", bus.state, 2);
        tick_with(B_CTRL);
        for (int i = 0; i < 1030; i++) tick_with((i % 2 == 0) ? B_RIGHT : B_LEFT);
        chk("moves_sat", bus.moves, 1023);
        chk("elapsed_run", bus.elapsed, 1032);

        // Reset mid-PLAY with a competing tick
        @(negedge CLK);
        RESET = 1'b0;
        bus.tick = 1'b1;
        bus.DOWNbtn = 1'b1;
        @(negedge CLK);
        RESET = 1'b1;
        bus.tick = 1'b0;
        bus.DOWNbtn = 1'b0;
        chk("rst_state", bus.state, 0);
        chk("rst_pos", bus.position, 181);
        chk("rst_lives", bus.lives, 3);
        chk("rst_moves", bus.moves, 0);
        chk("rst_elapsed", bus.elapsed, 0);
        chk("rst_pulses", {bus.step_pulse, bus.crash_pulse}, 0);
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
